// File: rtl/hpdcache_sram_fe_pkg.sv
// Shared types and constants for the hpdcache SRAM request front-end.
package hpdcache_sram_fe_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } fe_state_e;

  localparam int unsigned RSP_FIFO_DEPTH = 3;
  localparam int unsigned RSP_FIFO_CNT_W = 2;

endpackage

// File: rtl/hpdcache_sram_rsp_fifo.sv
// Three-entry in-order register FIFO holding SRAM read data until the consumer takes it.
module hpdcache_sram_rsp_fifo
  import hpdcache_sram_fe_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [DATA_SIZE-1:0]      push_data,
  input  logic                      pop,
  output logic [RSP_FIFO_CNT_W-1:0] count,
  output logic                      valid,
  output logic [DATA_SIZE-1:0]      head_data
);

  logic [DATA_SIZE-1:0]      mem_q [RSP_FIFO_DEPTH];
  logic [RSP_FIFO_CNT_W-1:0] wr_ptr_q;
  logic [RSP_FIFO_CNT_W-1:0] rd_ptr_q;
  logic [RSP_FIFO_CNT_W-1:0] count_q;
  logic                      pop_eff;

  function automatic logic [RSP_FIFO_CNT_W-1:0] next_ptr(input logic [RSP_FIFO_CNT_W-1:0] ptr);
    return (ptr == RSP_FIFO_CNT_W'(RSP_FIFO_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign pop_eff   = pop & valid;
  assign count     = count_q;
  assign valid     = (count_q != '0);
  assign head_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)    wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop_eff) rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({push, pop_eff})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; only entries covered by count are ever observed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/hpdcache_sram_fe.sv
// Valid/ready front-end for one hpdcache_sram macro: zero-fill after reset,
// credit-based read acceptance and a response FIFO absorbing back-pressure.
module hpdcache_sram_fe
  import hpdcache_sram_fe_pkg::*;
#(
  parameter int unsigned ADDR_SIZE     = 6,
  parameter int unsigned DATA_SIZE     = 64,
  parameter int unsigned DEPTH         = 2**ADDR_SIZE,
  parameter int unsigned INIT_ON_RESET = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [ADDR_SIZE-1:0] req_addr_i,
  input  logic [DATA_SIZE-1:0] req_wdata_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DATA_SIZE-1:0] rsp_rdata_o,
  output logic                 init_done_o,
  output logic                 sram_cs_o,
  output logic                 sram_we_o,
  output logic [ADDR_SIZE-1:0] sram_addr_o,
  output logic [DATA_SIZE-1:0] sram_wdata_o,
  input  logic [DATA_SIZE-1:0] sram_rdata_i
);

  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(DEPTH - 1);

  fe_state_e                 state_q, state_d;
  logic [ADDR_SIZE-1:0]      init_cnt_q, init_cnt_d;
  logic                      inflight_p1;
  logic [RSP_FIFO_CNT_W-1:0] fifo_count;
  logic                      fifo_valid;
  logic [DATA_SIZE-1:0]      fifo_head;
  logic [2:0]                credit_used;
  logic                      rd_credit;
  logic                      req_accept;
  logic                      rd_accept;
  logic                      rsp_pop;

  // Credits come only from registered state, so acceptance never waits on rsp_ready_i.
  assign credit_used = {1'b0, fifo_count} + {2'b00, inflight_p1};
  assign rd_credit   = (credit_used < 3'(RSP_FIFO_DEPTH));

  assign init_done_o = rst_n & (state_q == READY);
  assign req_ready_o = init_done_o & (req_we_i | rd_credit);
  assign req_accept  = req_valid_i & req_ready_o;
  assign rd_accept   = req_accept & ~req_we_i;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == INIT) begin
      if (INIT_ON_RESET == 0) begin
        state_d = READY;
      end else begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == LAST_ADDR) state_d = READY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // SRAM port: zero-fill writes during init, request pass-through once ready.
  always_comb begin
    sram_cs_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    if (rst_n) begin
      if (state_q == INIT) begin
        if (INIT_ON_RESET != 0) begin
          sram_cs_o   = 1'b1;
          sram_we_o   = 1'b1;
          sram_addr_o = init_cnt_q;
        end
      end else if (req_accept) begin
        sram_cs_o    = 1'b1;
        sram_we_o    = req_we_i;
        sram_addr_o  = req_addr_i;
        sram_wdata_o = req_wdata_i;
      end
    end
  end

  // Stage p1: SRAM read data is valid one edge after the accepting edge.
  always_ff @(posedge clk) begin
    if (!rst_n) inflight_p1 <= 1'b0;
    else        inflight_p1 <= rd_accept;
  end

  hpdcache_sram_rsp_fifo #(
    .DATA_SIZE (DATA_SIZE)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_p1),
    .push_data (sram_rdata_i),
    .pop       (rsp_pop),
    .count     (fifo_count),
    .valid     (fifo_valid),
    .head_data (fifo_head)
  );

  // Output stage: head of FIFO, forced to zero when nothing is presented.
  assign rsp_valid_o = rst_n & fifo_valid;
  assign rsp_rdata_o = rsp_valid_o ? fifo_head : '0;
  assign rsp_pop     = rsp_valid_o & rsp_ready_i;

endmodule
